// File: rtl/keccak_iota_seq.sv
// Iota stage for an iterative Keccak-p[25*LANE_W, NR] core: tracks the round index
// and XORs the round constant, generated by the rc(t) LFSR, into lane (0,0).
module keccak_iota_seq #(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned NR     = 12 + 2 * $clog2(LANE_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              adv_i,
   input  logic [LANE_W-1:0] lane_i,
   output logic [LANE_W-1:0] lane_o,
   output logic [LANE_W-1:0] rc_o,
   output logic [4:0]        rnd_o,
   output logic              busy_o,
   output logic              last_o,
   output logic              done_o
);

   localparam int unsigned L      = $clog2(LANE_W);
   localparam int unsigned NR_MAX = 12 + 2 * L;
   localparam int unsigned IR0    = NR_MAX - NR;
   localparam logic [4:0]  IR0_V  = 5'(IR0);
   localparam logic [4:0]  LAST_V = 5'(NR_MAX - 1);

   // One rc(t) step: multiply by x modulo x^8+x^6+x^5+x^4+1.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
   endfunction

   function automatic logic [7:0] seed_f(input int unsigned ir0);
      logic [7:0] s;
      s = 8'h01;
      for (int unsigned i = 0; i < 7 * ir0; i++) s = lfsr_step(s);
      return s;
   endfunction

   localparam logic [7:0] SEED = seed_f(IR0);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q;
   logic [7:0]  s_q;
   logic [7:0]  s_d;
   logic [4:0]  rnd_q;
   logic        done_q;
   logic [7:0]  chain [8];
   logic [LANE_W-1:0] rc_full;

   // chain[j] is the LFSR state at t = 7*ir + j; its bit 0 is rc(7*ir + j).
   assign chain[0] = s_q;
   for (genvar j = 0; j < 7; j++) begin : g_step
      assign chain[j+1] = lfsr_step(chain[j]);
   end
   assign s_d = chain[7];

   // Only bit positions 2^j-1 carry a constant bit; all others are zero.
   for (genvar b = 0; b < LANE_W; b++) begin : g_rc
      if (((b + 1) & b) == 0) begin : g_pos
         assign rc_full[b] = chain[$clog2(b + 1)][0];
      end else begin : g_zero
         assign rc_full[b] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= 8'h01;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            state_q <= RUN;
            s_q     <= SEED;
            rnd_q   <= IR0_V;
         end else if (adv_i && state_q == RUN) begin
            if (rnd_q == LAST_V) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end else begin
               s_q   <= s_d;
               rnd_q <= rnd_q + 5'd1;
            end
         end
      end
   end

   assign busy_o = (state_q == RUN);
   assign rc_o   = busy_o ? rc_full : '0;
   assign lane_o = lane_i ^ rc_o;
   assign rnd_o  = rnd_q;
   assign last_o = busy_o && (rnd_q == LAST_V);
   assign done_o = done_q;

endmodule

// File: doc/keccak_iota_seq.md
Name: keccak_iota_seq

Overview:
- Sequential, parametrised iota stage for the iterative Keccak-p[25·LANE_W, NR] permutation core.
- Round constants come from the FIPS-202 rc(t) LFSR, not a ROM, so the block serves every lane width (8..64) and reduced-round variants (e.g. NR=12 for KangarooTwelve).
- Tracks the round index under a start/advance handshake from the round controller.
- XORs the current constant into lane (0,0) of the theta-rho-pi-chi datapath output.

Parameters:
- LANE_W, 64: lane width; legal values 8, 16, 32, 64 (L = log2(LANE_W); L≥3 required).
- NR, 12+2·L: rounds executed; legal range 1..12+2·L; first round index IR0 = 12+2·L−NR.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  pulse: begin a permutation at round IR0
- adv_i  input  1  pulse: current round finished, advance to next round
- lane_i  input  LANE_W  lane (0,0) after chi
- lane_o  output  LANE_W  lane_i XOR rc_o (combinational)
- rc_o  output  LANE_W  round constant of current round; 0 when idle
- rnd_o  output  5  current round index ir (absolute Keccak index)
- busy_o  output  1  permutation in progress
- last_o  output  1  busy_o and rnd_o == 12+2·L−1
- done_o  output  1  one-cycle pulse after the final round is advanced

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, 8-bit LFSR reg=8'h01, rnd_o=0, busy_o=0, done_o=0, rc_o=0, last_o=0.
- LFSR polynomial x^8+x^6+x^5+x^4+1, Galois form per FIPS-202 rc(t).
  - reg S holds LFSR state at t=7·ir.
  - Combinational unroll gives rc(7·ir+j) for j=0..6.
  - rc_o bit (2^j−1) = rc(7·ir+j) for j=0..L; all other bits 0.
  - Result equals the 64-bit Keccak RC truncated to LANE_W bits.
- Seed: SEED = x^(7·IR0) mod poly, computed at elaboration by a constant function. No runtime pre-stepping. IR0=0 gives 8'h01.
- FSM states:
  - IDLE:
    - start_i → RUN; S←SEED; rnd_o←IR0; busy_o←1.
    - adv_i ignored.
    - rc_o forced 0, so lane_o=lane_i.
  - RUN:
    - adv_i with rnd_o < 12+2L−1: S←S stepped 7 times; rnd_o←rnd_o+1. Takes effect next cycle; latency 1.
    - adv_i with last_o=1: → IDLE; busy_o←0; done_o=1 for exactly one cycle; rnd_o holds last index.
- start_i in RUN aborts and restarts: S←SEED, rnd_o←IR0, no done_o pulse. start_i has priority over simultaneous adv_i in any state.
- adv_i held high advances one round per cycle. No stall beyond the caller's pacing.
- NR=1: first adv_i after start_i produces done_o immediately.
- rnd_o never exceeds 23 and never wraps. An adv_i in IDLE after completion changes nothing.
- lane_o path: purely combinational XOR, no register. Caller registers the state.
- Reset asserted mid-RUN: immediate return to reset values. No done_o pulse.

Test Plan:
- LANE_W=64, NR=24: start_i, then adv_i each cycle.
  - rc_o sequence is 0x1, 0x8082, 0x800000000000808A, … ending at ir=23 with 0x8000000080008008.
  - last_o high only at ir=23; done_o is one pulse on the cycle after the 24th adv_i; busy_o then 0.
- LANE_W=64, NR=12 (K12): start_i → rnd_o=12, rc_o=0x000000008000808B.
  - After 11 adv_i: rnd_o=23, rc_o=0x8000000080008008.
  - 12th adv_i → done_o.
- LANE_W=8, NR=18: rc_o sequence starts 0x01, 0x82, 0x8A.
  - ir=17 gives 0x80; last_o at ir=17.
  - With lane_i=0xFF at ir=1, lane_o=0x7D.
- Idle/priority: adv_i in IDLE leaves rnd_o and busy_o unchanged, rc_o=0, lane_o=lane_i.
  - start_i and adv_i in the same cycle → rnd_o=IR0, not IR0+1.
- Restart mid-run: at ir=7, assert start_i → next cycle rnd_o=IR0, rc_o=round-IR0 constant, no done_o.
- Async reset: assert rst between clock edges at ir=5 → busy_o, rc_o, rnd_o, done_o all 0 immediately, with no clk edge required.
